// File: rtl/ahbl_to_apb_bridge_pkg.sv
// ahbl_to_apb_bridge_pkg: bridge state encoding and AHB HTRANS codes.
package ahbl_to_apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never start a transfer.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahbl_to_apb_bridge.sv
// ahbl_to_apb_bridge: AHB-Lite single-transfer to APB3 bridge, one transfer in flight.
module ahbl_to_apb_bridge
    import ahbl_to_apb_bridge_pkg::*;
#(
    parameter int W_HADDR = 32,
    parameter int W_PADDR = 16,
    parameter int W_DATA  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ahbls_hready,
    output logic               ahbls_hready_resp,
    output logic               ahbls_hresp,
    input  logic [W_HADDR-1:0] ahbls_haddr,
    input  logic               ahbls_hwrite,
    input  logic [1:0]         ahbls_htrans,
    input  logic [2:0]         ahbls_hsize,
    input  logic [W_DATA-1:0]  ahbls_hwdata,
    output logic [W_DATA-1:0]  ahbls_hrdata,
    output logic [W_PADDR-1:0] apbm_paddr,
    output logic               apbm_psel,
    output logic               apbm_penable,
    output logic               apbm_pwrite,
    output logic [W_DATA-1:0]  apbm_pwdata,
    input  logic [W_DATA-1:0]  apbm_prdata,
    input  logic               apbm_pready,
    input  logic               apbm_pslverr
);

    state_e             state_q, state_d;
    logic               hready_resp_q, hresp_q, psel_q, penable_q, pwrite_q;
    logic [W_PADDR-1:0] paddr_q;
    logic [W_DATA-1:0]  pwdata_q, hrdata_q;
    logic               accept;
    logic               unused;

    // Transfer size is ignored (everything is a full word) and the upper address bits are decoded upstream.
    assign unused = ^{ahbls_hsize, ahbls_haddr[W_HADDR-1:W_PADDR]};

    always_comb begin
        accept  = ahbls_hready && htrans_active(ahbls_htrans) &&
                  (state_q == ST_IDLE || state_q == ST_RESP || state_q == ST_ERR2);
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE, ST_RESP, ST_ERR2:
                state_d = accept ? (ahbls_hwrite ? ST_WDATA : ST_SETUP) : ST_IDLE;
            ST_WDATA:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: state_d = apbm_pready ? (apbm_pslverr ? ST_ERR1 : ST_RESP) : ST_ACCESS;
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hready_resp_q <= 1'b1;
            hresp_q       <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            hrdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            hready_resp_q <= state_d inside {ST_IDLE, ST_RESP, ST_ERR2};
            hresp_q       <= state_d inside {ST_ERR1, ST_ERR2};
            psel_q        <= state_d inside {ST_SETUP, ST_ACCESS};
            penable_q     <= state_d == ST_ACCESS;
            if (accept) begin
                paddr_q  <= ahbls_haddr[W_PADDR-1:0];
                pwrite_q <= ahbls_hwrite;
            end
            if (state_q == ST_WDATA)
                pwdata_q <= ahbls_hwdata;
            if (state_q == ST_ACCESS && apbm_pready && !apbm_pslverr && !pwrite_q)
                hrdata_q <= apbm_prdata;
        end
    end

    assign ahbls_hready_resp = hready_resp_q;
    assign ahbls_hresp       = hresp_q;
    assign ahbls_hrdata      = hrdata_q;
    assign apbm_paddr        = paddr_q;
    assign apbm_psel         = psel_q;
    assign apbm_penable      = penable_q;
    assign apbm_pwrite       = pwrite_q;
    assign apbm_pwdata       = pwdata_q;

endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
// tb_ahbl_to_apb_bridge: directed self-checking bench for the AHB-Lite to APB3 bridge.
module tb_ahbl_to_apb_bridge;
    import ahbl_to_apb_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hready;
    logic        hready_resp;
    logic        hresp;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ahbl_to_apb_bridge dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ahbls_hready      (hready),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hresp       (hresp),
        .ahbls_haddr       (haddr),
        .ahbls_hwrite      (hwrite),
        .ahbls_htrans      (htrans),
        .ahbls_hsize       (hsize),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata),
        .apbm_paddr        (paddr),
        .apbm_psel         (psel),
        .apbm_penable      (penable),
        .apbm_pwrite       (pwrite),
        .apbm_pwdata       (pwdata),
        .apbm_prdata       (prdata),
        .apbm_pready       (pready),
        .apbm_pslverr      (pslverr)
    );

    // Inputs change and outputs are sampled on the falling edge; sample j cycles after the address phase is cycle N+j.
    task automatic test_reset;
        rst_n = 1'b0; hready = 1'b1; haddr = '0; hwrite = 1'b0; htrans = HTRANS_IDLE;
        hsize = 3'd2; hwdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({hready_resp, hresp, psel, penable, pwrite} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctrl: got ready/resp/psel/pen/pwrite=%b expected 10000",
                     {hready_resp, hresp, psel, penable, pwrite});
        end
        tests++;
        if ({hrdata, paddr, pwdata} !== 80'h0) begin
            fails++;
            $display("FAIL reset_data: got hrdata=%h paddr=%h pwdata=%h expected zeros", hrdata, paddr, pwdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        int psel_cnt = 0;
        @(negedge clk);
        haddr = 32'h4000000c; hwrite = 1'b1; htrans = HTRANS_NONSEQ; pready = 1'b1; pslverr = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) begin htrans = HTRANS_IDLE; hwdata = 32'h41; end
            if (j == 2) hwdata = 32'hffffffff;
            psel_cnt += int'(psel);
            tests++;
            if (hready_resp !== (j >= 4)) begin
                fails++;
                $display("FAIL wr_hready N+%0d: got %b expected %b", j, hready_resp, j >= 4);
            end
            if (j == 2) begin
                tests++;
                if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 16'h000c, 32'h41}) begin
                    fails++;
                    $display("FAIL wr_setup: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h expected 1 0 1 000c 00000041",
                             psel, penable, pwrite, paddr, pwdata);
                end
            end
            if (j == 3) begin
                tests++;
                if ({psel, penable, paddr, pwdata} !== {2'b11, 16'h000c, 32'h41}) begin
                    fails++;
                    $display("FAIL wr_access: got psel=%b pen=%b paddr=%h pwdata=%h expected 1 1 000c 00000041",
                             psel, penable, paddr, pwdata);
                end
            end
        end
        tests++;
        if (psel_cnt != 2) begin
            fails++;
            $display("FAIL wr_psel_cycles: got %0d expected 2", psel_cnt);
        end
    endtask

    task automatic test_read_wait;
        int pen_cnt = 0;
        @(negedge clk);
        haddr = 32'h00000010; hwrite = 1'b0; htrans = HTRANS_NONSEQ; pready = 1'b0; prdata = 32'hdeadbeef;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 1) htrans = HTRANS_IDLE;
            pen_cnt += int'(penable);
            if (j == 3) begin
                tests++;
                if ({psel, penable, pwrite, paddr, hready_resp} !== {3'b110, 16'h0010, 1'b0}) begin
                    fails++;
                    $display("FAIL rd_wait_access: got psel=%b pen=%b pwrite=%b paddr=%h ready=%b expected 1 1 0 0010 0",
                             psel, penable, pwrite, paddr, hready_resp);
                end
            end
            if (j == 4) pready = 1'b1;
            if (j == 5) begin
                prdata = 32'h0;
                tests++;
                if ({hready_resp, hresp, psel, hrdata} !== {3'b100, 32'hdeadbeef}) begin
                    fails++;
                    $display("FAIL rd_wait_resp: got ready=%b resp=%b psel=%b hrdata=%h expected 1 0 0 deadbeef",
                             hready_resp, hresp, psel, hrdata);
                end
            end
        end
        tests++;
        if (pen_cnt != 3) begin
            fails++;
            $display("FAIL rd_penable_cycles: got %0d expected 3", pen_cnt);
        end
        tests++;
        if (hrdata !== 32'hdeadbeef) begin
            fails++;
            $display("FAIL rd_hrdata_hold: got %h expected deadbeef", hrdata);
        end
    endtask

    task automatic test_slverr;
        @(negedge clk);
        haddr = 32'h00000020; hwrite = 1'b1; htrans = HTRANS_NONSEQ; pready = 1'b1; pslverr = 1'b1;
        prdata = 32'h55555555;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 1) begin htrans = HTRANS_IDLE; hwdata = 32'h77; end
            if (j >= 4) begin
                tests++;
                if ({hresp, hready_resp} !== ((j == 4) ? 2'b10 : (j == 5) ? 2'b11 : 2'b01)) begin
                    fails++;
                    $display("FAIL err_phase N+%0d: got resp/ready=%b%b expected %b", j, hresp, hready_resp,
                             (j == 4) ? 2'b10 : (j == 5) ? 2'b11 : 2'b01);
                end
            end
        end
        pslverr = 1'b0;
        tests++;
        if ({psel, hrdata} !== {1'b0, 32'hdeadbeef}) begin
            fails++;
            $display("FAIL err_after: got psel=%b hrdata=%h expected 0 deadbeef", psel, hrdata);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        haddr = 32'h00000030; hwrite = 1'b0; htrans = HTRANS_NONSEQ; pready = 1'b1; prdata = 32'h12345678;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 1) htrans = HTRANS_IDLE;
            if (j == 3) begin
                tests++;
                if ({hready_resp, hrdata} !== {1'b1, 32'h12345678}) begin
                    fails++;
                    $display("FAIL b2b_read_resp: got ready=%b hrdata=%h expected 1 12345678", hready_resp, hrdata);
                end
                haddr = 32'h00000034; hwrite = 1'b1; htrans = HTRANS_NONSEQ;
            end
            if (j == 4) begin
                htrans = HTRANS_IDLE; hwdata = 32'hcafe0001;
                tests++;
                if ({hready_resp, psel} !== 2'b00) begin
                    fails++;
                    $display("FAIL b2b_wdata: got ready=%b psel=%b expected 0 0", hready_resp, psel);
                end
            end
            if (j == 5) begin
                tests++;
                if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 16'h0034, 32'hcafe0001}) begin
                    fails++;
                    $display("FAIL b2b_setup: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h expected 1 0 1 0034 cafe0001",
                             psel, penable, pwrite, paddr, pwdata);
                end
            end
            if (j == 7) begin
                tests++;
                if ({hready_resp, hresp, psel, hrdata} !== {3'b100, 32'h12345678}) begin
                    fails++;
                    $display("FAIL b2b_write_resp: got ready=%b resp=%b psel=%b hrdata=%h expected 1 0 0 12345678",
                             hready_resp, hresp, psel, hrdata);
                end
            end
        end
    endtask

    task automatic test_no_transfer;
        int bad = 0;
        @(negedge clk);
        haddr = 32'h00000040; hwrite = 1'b1; htrans = HTRANS_BUSY; hready = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 3) begin htrans = HTRANS_NONSEQ; hready = 1'b0; end
            if (psel !== 1'b0 || hready_resp !== 1'b1) bad++;
        end
        htrans = HTRANS_IDLE; hready = 1'b1;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL no_transfer: got %0d cycles with psel/ready disturbed expected 0", bad);
        end
    endtask

    task automatic test_reset_in_access;
        @(negedge clk);
        haddr = 32'h00000050; hwrite = 1'b0; htrans = HTRANS_NONSEQ; pready = 1'b0; prdata = 32'h99999999;
        @(negedge clk); htrans = HTRANS_IDLE;
        @(negedge clk);
        tests++;
        if ({psel, penable} !== 2'b11) begin
            fails++;
            $display("FAIL rst_pre_access: got psel=%b pen=%b expected 1 1", psel, penable);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({psel, penable, hresp, hready_resp} !== 4'b0001) begin
            fails++;
            $display("FAIL rst_async: got psel/pen/resp/ready=%b expected 0001", {psel, penable, hresp, hready_resp});
        end
        pready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        haddr = 32'h00000044; hwrite = 1'b0; htrans = HTRANS_NONSEQ; prdata = 32'h0badf00d;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            if (j == 1) htrans = HTRANS_IDLE;
            if (j == 1) begin
                tests++;
                if ({psel, penable, paddr} !== {2'b10, 16'h0044}) begin
                    fails++;
                    $display("FAIL rst_next_setup: got psel=%b pen=%b paddr=%h expected 1 0 0044", psel, penable, paddr);
                end
            end
        end
        tests++;
        if ({hready_resp, hrdata} !== {1'b1, 32'h0badf00d}) begin
            fails++;
            $display("FAIL rst_next_read: got ready=%b hrdata=%h expected 1 0badf00d", hready_resp, hrdata);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_wait;
        test_slverr;
        test_back_to_back;
        test_no_transfer;
        test_reset_in_access;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
